// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
// Round-robin arbiter that shares one SPI link among NREQ requesters.
// Each grant moves one byte MSB first. mosi changes on the falling edge of
// sclk and miso is captured on that same falling edge. The slave samples
// mosi on the rising edge of sclk. Every output comes straight from a flop.
module spi_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] tx_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(CLK_DIV + CS_GAP + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [PW-1:0] LAST_OWNER = PW'(NREQ - 1);
  localparam logic [3:0]    HALF_LAST  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t state_r, state_s;

  logic [CW-1:0]   cnt_r, cnt_s;
  logic [3:0]      half_r, half_s;
  logic [PW-1:0]   owner_r, owner_s;
  logic [PW-1:0]   rr_r, rr_s;
  logic [6:0]      tx_sh_r, tx_sh_s;
  logic [7:0]      rx_sh_r, rx_sh_s;
  logic [NREQ-1:0] grant_r, grant_s;
  logic [NREQ-1:0] done_r, done_s;
  logic [7:0]      rx_data_r, rx_data_s;
  logic            busy_r, busy_s;
  logic            sclk_r, sclk_s;
  logic            cs_r, cs_s;
  logic            mosi_r, mosi_s;
  logic [PW-1:0]   sel_owner_s;
  logic [7:0]      sel_byte_s;
  logic            half_end_s;

  // First requester at or above ptr, wrapping around past NREQ-1.
  function automatic logic [PW-1:0] pick_owner(input logic [NREQ-1:0] r,
                                               input logic [PW-1:0]   ptr);
    logic [PW-1:0] sel;
    logic [PW:0]   sum;
    logic          hit;
    sel = ptr;
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      if (!hit && r[sum[PW-1:0]]) begin
        sel = sum[PW-1:0];
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  // Byte lane idx of the packed tx_data bus.
  function automatic logic [7:0] pick_byte(input logic [8*NREQ-1:0] d,
                                           input logic [PW-1:0]     idx);
    logic [7:0] b;
    b = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == idx) begin
        b = d[8*i +: 8];
      end
    end
    return b;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. Each phase ends on the last cycle of its counter.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (|req) state_s = ST_SETUP; else state_s = ST_IDLE;
      ST_SETUP: if (cnt_r == DIV_LAST) state_s = ST_XFER; else state_s = ST_SETUP;
      ST_XFER:  if (half_end_s && (half_r == HALF_LAST)) state_s = ST_HOLD;
                else state_s = ST_XFER;
      ST_HOLD:  if (cnt_r == DIV_LAST) state_s = ST_GAP; else state_s = ST_HOLD;
      ST_GAP:   if (cnt_r == GAP_LAST) state_s = ST_IDLE; else state_s = ST_GAP;
      default:  state_s = ST_IDLE;
    endcase
  end

  assign half_end_s = (cnt_r == DIV_LAST);

  // Output and datapath next values. These are registered below, so each
  // pin changes on the same edge as the state it belongs to.
  always_comb begin
    cnt_s       = cnt_r;
    half_s      = half_r;
    owner_s     = owner_r;
    rr_s        = rr_r;
    tx_sh_s     = tx_sh_r;
    rx_sh_s     = rx_sh_r;
    grant_s     = grant_r;
    done_s      = '0;
    rx_data_s   = rx_data_r;
    busy_s      = busy_r;
    sclk_s      = sclk_r;
    cs_s        = cs_r;
    mosi_s      = mosi_r;
    sel_owner_s = pick_owner(req, rr_r);
    sel_byte_s  = pick_byte(tx_data, sel_owner_s);
    case (state_r)
      ST_IDLE: begin
        cnt_s  = '0;
        half_s = 4'd0;
        sclk_s = 1'b0;
        if (|req) begin
          grant_s = NREQ'(1) << sel_owner_s;
          owner_s = sel_owner_s;
          tx_sh_s = sel_byte_s[6:0];
          mosi_s  = sel_byte_s[7];
          busy_s  = 1'b1;
          cs_s    = 1'b0;
        end else begin
          busy_s  = 1'b0;
          cs_s    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_r == DIV_LAST) cnt_s = '0;
        else cnt_s = cnt_r + CW'(1);
      end
      ST_XFER: begin
        if (half_end_s) begin
          cnt_s  = '0;
          half_s = half_r + 4'd1;
          sclk_s = ~sclk_r;
          // Falling edge: capture miso, then present the next tx bit
          // unless this was the eighth falling edge.
          if (sclk_r) begin
            rx_sh_s = {rx_sh_r[6:0], miso};
            if (half_r != HALF_LAST) begin
              mosi_s  = tx_sh_r[6];
              tx_sh_s = {tx_sh_r[5:0], 1'b0};
            end else begin
              mosi_s  = mosi_r;
            end
          end else begin
            rx_sh_s = rx_sh_r;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_HOLD: begin
        sclk_s = 1'b0;
        if (cnt_r == DIV_LAST) begin
          cnt_s     = '0;
          cs_s      = 1'b1;
          rx_data_s = rx_sh_r;
          done_s    = grant_r;
          grant_s   = '0;
          // The owner just served drops to lowest priority.
          if (owner_r == LAST_OWNER) rr_s = '0;
          else rr_s = owner_r + PW'(1);
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_GAP: begin
        cs_s = 1'b1;
        if (cnt_r == GAP_LAST) begin
          cnt_s  = '0;
          busy_s = 1'b0;
        end else begin
          cnt_s  = cnt_r + CW'(1);
        end
      end
      default: begin
        cnt_s   = '0;
        half_s  = 4'd0;
        grant_s = '0;
        busy_s  = 1'b0;
        sclk_s  = 1'b0;
        cs_s    = 1'b1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      half_r    <= 4'd0;
      owner_r   <= '0;
      rr_r      <= '0;
      tx_sh_r   <= 7'd0;
      rx_sh_r   <= 8'd0;
      grant_r   <= '0;
      done_r    <= '0;
      rx_data_r <= 8'd0;
      busy_r    <= 1'b0;
      sclk_r    <= 1'b0;
      cs_r      <= 1'b1;
      mosi_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      half_r    <= half_s;
      owner_r   <= owner_s;
      rr_r      <= rr_s;
      tx_sh_r   <= tx_sh_s;
      rx_sh_r   <= rx_sh_s;
      grant_r   <= grant_s;
      done_r    <= done_s;
      rx_data_r <= rx_data_s;
      busy_r    <= busy_s;
      sclk_r    <= sclk_s;
      cs_r      <= cs_s;
      mosi_r    <= mosi_s;
    end
  end

  assign grant   = grant_r;
  assign done    = done_r;
  assign rx_data = rx_data_r;
  assign busy    = busy_r;
  assign sclk    = sclk_r;
  assign cs      = cs_r;
  assign mosi    = mosi_r;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter
// Randomised and directed transactions against a simple SPI slave and a
// round-robin reference model. dut0 runs with CLK_DIV=2 and dut1 with
// CLK_DIV=1 in loopback.
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req0 = 4'd0, req1 = 4'd0;
  logic [31:0] tx_data = 32'd0;
  logic [3:0]  grant0, done0, grant1, done1;
  logic [7:0]  rx0, rx1;
  logic        busy0, sclk0, cs0, mosi0, miso0;
  logic        busy1, sclk1, cs1, mosi1, miso1;

  logic        use1 = 1'b0, lb = 1'b1, drop = 1'b0, abort3 = 1'b0;
  logic [7:0]  slv_data = 8'd0, slv_cap = 8'd0;
  logic [2:0]  bit_k = 3'd0;
  logic        slv_miso = 1'b0;
  logic [3:0]  last_grant = 4'd0;
  int          rr_model = 0;
  int          n_pass = 0, n_chk = 0;

  logic [3:0]  m_grant, m_done;
  logic [7:0]  m_rx;
  logic        m_busy, m_sclk, m_cs;

  always #5 clk = ~clk;

  spi_master_arbiter #(.NREQ(4), .CLK_DIV(2), .CS_GAP(2)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .tx_data(tx_data), .grant(grant0),
    .done(done0), .rx_data(rx0), .busy(busy0), .sclk(sclk0), .cs(cs0),
    .mosi(mosi0), .miso(miso0));

  spi_master_arbiter #(.NREQ(4), .CLK_DIV(1), .CS_GAP(2)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .tx_data(tx_data), .grant(grant1),
    .done(done1), .rx_data(rx1), .busy(busy1), .sclk(sclk1), .cs(cs1),
    .mosi(mosi1), .miso(miso1));

  assign miso0   = lb ? mosi0 : slv_miso;
  assign miso1   = mosi1;
  assign m_grant = use1 ? grant1 : grant0;
  assign m_done  = use1 ? done1  : done0;
  assign m_rx    = use1 ? rx1    : rx0;
  assign m_busy  = use1 ? busy1  : busy0;
  assign m_sclk  = use1 ? sclk1  : sclk0;
  assign m_cs    = use1 ? cs1    : cs0;

  // SPI slave: samples mosi and shifts out slv_data MSB first on sclk rise.
  always @(posedge sclk0 or posedge cs0) begin
    if (cs0) begin
      bit_k <= 3'd0;
    end else begin
      slv_miso <= slv_data[3'd7 - bit_k];
      slv_cap  <= {slv_cap[6:0], mosi0};
      bit_k    <= bit_k + 3'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  task automatic run_txn(input logic [3:0] rq);
    int d, owner, lat, low_cnt, rises, falls, gap, dcnt;
    logic [3:0] exp_g;
    logic [7:0] exp_tx, exp_rx;
    logic prev_sclk, g_ok, gap_ok, aborted;
    d       = use1 ? 1 : 2;
    owner   = rr_pick(rq, rr_model);
    exp_g   = 4'b0001 << owner;
    exp_tx  = tx_data[8*owner +: 8];
    exp_rx  = lb ? exp_tx : slv_data;
    if (use1) req1 = rq; else req0 = rq;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (m_grant == 4'd0 && lat < 20);
    check_eq("grant", 32'(m_grant), 32'(exp_g));
    check_eq("grant_latency", 32'(lat), 32'd1);
    check_eq("busy_at_grant", 32'(m_busy), 32'd1);
    last_grant = m_grant;
    tx_data = $urandom();
    low_cnt = 0; rises = 0; falls = 0; g_ok = 1'b1; aborted = 1'b0;
    prev_sclk = m_sclk;
    while (m_cs == 1'b0 && low_cnt < 300) begin
      low_cnt++;
      if (m_grant != exp_g || m_busy != 1'b1 || m_done != 4'd0) g_ok = 1'b0;
      if (low_cnt == 2 && drop) begin
        if (use1) req1[owner] = 1'b0; else req0[owner] = 1'b0;
      end
      if (abort3 && falls == 3) begin
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_cs", 32'(m_cs), 32'd1);
        check_eq("rst_sclk", 32'(m_sclk), 32'd0);
        check_eq("rst_grant", 32'(m_grant), 32'd0);
        check_eq("rst_busy", 32'(m_busy), 32'd0);
        rst = 1'b0;
        rr_model = 0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      if (m_sclk && !prev_sclk) rises++;
      if (!m_sclk && prev_sclk) falls++;
      prev_sclk = m_sclk;
    end
    req0 = 4'd0;
    req1 = 4'd0;
    if (aborted) return;
    check_eq("cs_low_cycles", 32'(low_cnt), 32'(18 * d));
    check_eq("sclk_rises", 32'(rises), 32'd8);
    check_eq("grant_stable", 32'(g_ok), 32'd1);
    check_eq("done_pulse", 32'(m_done), 32'(exp_g));
    check_eq("grant_cleared", 32'(m_grant), 32'd0);
    check_eq("rx_data", 32'(m_rx), 32'(exp_rx));
    if (!use1 && !lb) check_eq("slave_capture", 32'(slv_cap), 32'(exp_tx));
    rr_model = (owner + 1) % 4;
    gap = 0; dcnt = 0; gap_ok = 1'b1;
    while (m_busy && gap < 50) begin
      gap++;
      if (m_done != 4'd0) dcnt++;
      if (m_cs != 1'b1 || m_sclk != 1'b0) gap_ok = 1'b0;
      @(negedge clk);
    end
    check_eq("gap_cycles", 32'(gap), 32'd2);
    check_eq("gap_cs_high", 32'(gap_ok), 32'd1);
    check_eq("done_width", 32'(dcnt), 32'd1);
    check_eq("rx_held", 32'(m_rx), 32'(exp_rx));
  endtask

  task automatic idle_check;
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cs0 != 1'b1 || sclk0 != 1'b0 || busy0 != 1'b0 || grant0 != 4'd0) ok = 1'b0;
    end
    check_eq("idle_static", 32'(ok), 32'd1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
  endtask

  initial begin
    logic [3:0] seq [5];
    logic [3:0] rq;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (3) @(negedge clk);
    check_eq("reset_cs", 32'(cs0), 32'd1);
    check_eq("reset_sclk", 32'(sclk0), 32'd0);
    check_eq("reset_mosi", 32'(mosi0), 32'd0);
    check_eq("reset_grant", 32'(grant0), 32'd0);
    check_eq("reset_done", 32'(done0), 32'd0);
    check_eq("reset_busy", 32'(busy0), 32'd0);
    check_eq("reset_rx", 32'(rx0), 32'd0);
    rst = 1'b0;
    idle_check();

    // Loopback 0xA5 from requester 0.
    lb = 1'b1; tx_data = 32'h000000A5;
    run_txn(4'b0001);
    // Slave returns 0x5A while requester 1 sends 0xC3.
    lb = 1'b0; slv_data = 8'h5A; tx_data = 32'h0000C300;
    run_txn(4'b0010);
    // Everyone requesting: strict rotation from requester 0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tx_data = $urandom(); slv_data = 8'($urandom());
      run_txn(4'b1111);
      check_eq("rr_sequence", 32'(last_grant), 32'(seq[i]));
    end
    // Requester 2 withdraws right after its grant.
    drop = 1'b1; tx_data = $urandom();
    run_txn(4'b0100);
    drop = 1'b0;
    // Reset in the middle of the shift, then a fresh full transfer.
    abort3 = 1'b1; lb = 1'b1; tx_data = $urandom();
    run_txn(4'b0100);
    abort3 = 1'b0;
    @(negedge clk);
    tx_data = 32'h3C00007E;
    run_txn(4'b1001);
    check_eq("after_reset_owner", 32'(last_grant), 32'd1);
    idle_check();

    // CLK_DIV=1 loopback of 0x01.
    use1 = 1'b1; tx_data = 32'h00000001;
    run_txn(4'b0001);
    use1 = 1'b0;
    rr_model = 1;

    // Random traffic on dut0.
    for (int n = 0; n < 24; n++) begin
      lb       = 1'($urandom_range(0, 1));
      drop     = ($urandom_range(0, 3) == 0);
      tx_data  = $urandom();
      slv_data = 8'($urandom());
      rq       = 4'($urandom_range(1, 15));
      run_txn(rq);
    end
    drop = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
